// File: rtl/seven_segment_display_seq_pkg.sv
// Shared definitions for the sequential seven-segment driver: FSM states,
// active-high segment patterns (gfedcba) and a constant power-of-ten helper.
package seven_segment_display_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] digit_pattern(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Elaboration-time only; DIGITS is at most 8 so 64 bits is ample.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_display_seq_decoder.sv
// Combinational BCD nibble to active-high seven-segment pattern, with
// dash (overflow) taking priority over blank.
module seven_segment_display_seq_decoder
  import seven_segment_display_seq_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (dash) begin
      pattern = SEG_DASH;
    end else if (!blank) begin
      pattern = digit_pattern(nibble);
    end
  end

endmodule

// File: rtl/seven_segment_display_seq.sv
// Sequential binary-to-seven-segment driver: double-dabble one bit per clock,
// then registers BCD, segment patterns and overflow with a one-cycle done pulse.
module seven_segment_display_seq
  import seven_segment_display_seq_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
  localparam logic [7*DIGITS-1:0] SEG_OFF = ACTIVE_LOW ? '1 : '0;

  state_t            state_reg, state_next;
  logic [SH_W-1:0]   sh_reg, sh_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_pend_reg, ovf_pend_next;
  logic              done_reg;
  logic              ovf_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [7*DIGITS-1:0] seg_reg;

  logic [SH_W-1:0]     add3_sh;
  logic [BCD_W-1:0]    res_bcd;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_pat;
  logic [7*DIGITS-1:0] seg_drive;

  assign add3_sh[WIDTH-1:0] = sh_reg[WIDTH-1:0];
  assign res_bcd = sh_reg[SH_W-1:WIDTH];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = sh_reg[WIDTH + 4*gi +: 4];
      // Nibble carry past 4 bits is dropped; only reachable on overflow.
      assign add3_sh[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;

      if (gi > 0) begin : g_lz
        assign blank[gi] = BLANK_LZ && (res_bcd[BCD_W-1:4*gi] == '0);
      end else begin : g_units
        assign blank[gi] = 1'b0;
      end

      seven_segment_display_seq_decoder u_dec (
        .nibble  (res_bcd[4*gi +: 4]),
        .blank   (blank[gi]),
        .dash    (ovf_pend_reg),
        .pattern (seg_pat[7*gi +: 7])
      );
    end
  endgenerate

  assign seg_drive = ACTIVE_LOW ? ~seg_pat : seg_pat;

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sh_next       = {{BCD_W{1'b0}}, bin};
          cnt_next      = '0;
          ovf_pend_next = (64'(bin) > LIMIT);
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_next  = {add3_sh[SH_W-2:0], 1'b0};
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sh_reg       <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      bcd_reg      <= '0;
      seg_reg      <= SEG_OFF;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      done_reg     <= (state_reg == ST_DONE);
      if (state_reg == ST_DONE) begin
        ovf_reg <= ovf_pend_reg;
        bcd_reg <= ovf_pend_reg ? '0 : res_bcd;
        seg_reg <= seg_drive;
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign ovf  = ovf_reg;
  assign bcd  = bcd_reg;
  assign seg  = seg_reg;

endmodule
